// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply / multiply-accumulate sequencer that borrows the shared
// ALU for one add per cycle through a req/gnt handshake and returns {N,Z} flags.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Product,
  output logic [1:0]       Flags,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] AluSrcA,
  output logic [WIDTH-1:0] AluSrcB,
  output logic [2:0]       AluControl,
  output logic             AluCarry,
  input  logic [WIDTH-1:0] AluResult
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mult;
  logic [WIDTH-1:0] w_mult_shr;
  logic [WIDTH-1:0] w_seed;
  logic             w_in_iter;

  function automatic logic [1:0] nz_flags(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], (v == '0)};
  endfunction

  assign w_in_iter  = (r_state == S_ITER);
  assign w_mult_shr = r_mult >> 1;
  assign w_seed     = accumulate ? Acc : '0;

  // ALU drive depends only on registered state, never on alu_gnt.
  assign alu_req    = w_in_iter;
  assign AluSrcA    = w_in_iter ? r_acc : '0;
  assign AluSrcB    = (w_in_iter && r_mult[0]) ? r_mcand : '0;
  assign AluControl = 3'b000;
  assign AluCarry   = 1'b0;

  assign busy  = w_in_iter;
  assign done  = (r_state == S_DONE);
  assign Flags = nz_flags(Product);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mult  <= '0;
      Product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand <= A;
            r_mult  <= B;
            r_acc   <= w_seed;
            if (B == '0) begin
              Product <= w_seed;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ITER;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ITER: begin
          // A dropped grant freezes every register, so the operands stay put.
          if (alu_gnt) begin
            r_acc   <= AluResult;
            r_mcand <= r_mcand << 1;
            r_mult  <= w_mult_shr;
            if (w_mult_shr == '0) begin
              Product <= AluResult;
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
